imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit instruction words.
REQ-002 SHALL have parameter AW, default 5, meaning address width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request to begin a program load.
REQ-006 SHALL have port word_count, input, AW+1, number of words to load (sampled on accepted start).
REQ-007 SHALL have port abort, input, 1, terminate an in-progress load.
REQ-008 SHALL have port byte_valid, input, 1, byte_data is valid.
REQ-009 SHALL have port byte_data, input, 8, program byte stream, most significant byte of each word first.
REQ-010 SHALL have port byte_ready, output, 1, loader accepts byte this cycle.
REQ-011 SHALL have port busy, output, 1, load in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the final word is written.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on an illegal start.
REQ-014 SHALL have port addr, input, AW, CPU instruction fetch address.
REQ-015 SHALL have port data, output, 32, instruction word at addr, combinational read.

Function
REQ-016 SHALL implement states IDLE, LOAD, DONE.
REQ-017 IDLE: start=1 with 1 <= word_count <= DEPTH SHALL latch word_count, clear write address and byte index, go to LOAD.
REQ-018 IDLE: start=1 with word_count=0 or word_count>DEPTH SHALL pulse err for one cycle and stay in IDLE.
REQ-019 byte_ready SHALL be 1 only in LOAD; busy SHALL be 1 exactly in LOAD.
REQ-020 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1; byte_valid gaps SHALL stall assembly with no state change.
REQ-021 Accepted bytes SHALL be assembled big-endian: byte 0 -> bits 31:24, byte 3 -> bits 7:0.
REQ-022 On the edge accepting byte 3, the assembled word SHALL be written to memory at the write address, the write address SHALL increment, and the byte index SHALL return to 0.
REQ-023 When the written word is the word_count-th, the FSM SHALL go to DONE on that edge; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 The write address SHALL never wrap; the maximum written address is DEPTH-1 (word_count=DEPTH).
REQ-025 start in LOAD or DONE SHALL be ignored.
REQ-026 abort=1 in LOAD SHALL return to IDLE on the next edge, discarding the partial word; words already written SHALL be kept; done SHALL NOT pulse; abort has priority over a simultaneous byte acceptance.
REQ-027 data SHALL equal mem[addr] combinationally at all times, including during LOAD; a same-cycle write to addr SHALL become visible after the clock edge.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, byte_ready=0, busy=0, done=0, err=0, and clear write address, byte index, latched count and partial word.
REQ-029 Memory contents SHALL NOT be reset; reset mid-load SHALL leave already-written words intact.

Structure
REQ-030 The FSM state enum, DEPTH default and word/byte width constants SHALL live in a shared package used by the CPU fetch stage.
REQ-031 Storage SHALL be a sub-module imem_ram: DEPTH x 32, one synchronous write port, one asynchronous read port.

Verification
REQ-032 word_count=2, bytes 00 00 28 00 00 00 08 00 back-to-back -> mem[0]=0x00002800, mem[1]=0x00000800, done pulses on the cycle after byte 8 is accepted, busy high for 8 cycles.
REQ-033 word_count=1, bytes 8C 23 00 00 with byte_valid low for 2 cycles between each -> mem[0]=0x8C230000, done once, no extra writes.
REQ-034 start with word_count=0, then with word_count=33 -> err pulses once each, busy stays 0, memory unchanged.
REQ-035 word_count=3, abort asserted after 6 bytes accepted -> mem[0] written, mem[1] unchanged, IDLE next cycle, no done.
REQ-036 word_count=32, 128 bytes -> addresses 0..31 written with their words, done once, address 0 not rewritten.
REQ-037 rst_n pulled low after 5 bytes of a 2-word load -> immediate IDLE, mem[0] retained, next load starts at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the CPU fetch stage.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEF      = 32;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory while the CPU can keep fetching.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] data
);

    localparam int unsigned PART_W  = WORD_W - BYTE_W;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [1:0]  LAST_IX = 2'(BYTES_PER_WORD - 1);

    loader_state_t     state, state_next;
    logic [AW:0]       count_q;
    logic [AW:0]       waddr_q;
    logic [1:0]        idx_q;
    logic [PART_W-1:0] part_q;

    logic busy_d, ready_d, done_d, err_d;
    logic load_c, accept_c, write_c, abort_c;
    logic count_ok_c;

    assign count_ok_c = (word_count != '0) && (word_count <= DEPTH_W);

    // Next-state decode and registered-output next values.
    always_comb begin
        state_next = state;
        err_d      = 1'b0;
        load_c     = 1'b0;
        accept_c   = 1'b0;
        write_c    = 1'b0;
        abort_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (count_ok_c) begin
                        load_c     = 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Abort wins over a byte offered in the same cycle.
                if (abort) begin
                    abort_c    = 1'b1;
                    state_next = ST_IDLE;
                end else if (byte_valid) begin
                    accept_c = 1'b1;
                    if (idx_q == LAST_IX) begin
                        write_c = 1'b1;
                        if (waddr_q + (AW+1)'(1) == count_q) begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        busy_d  = (state_next == ST_LOAD);
        ready_d = (state_next == ST_LOAD);
        done_d  = (state_next == ST_DONE);
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= busy_d;
            byte_ready <= ready_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Word assembly: count latch, write address, byte index and partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            waddr_q <= '0;
            idx_q   <= '0;
            part_q  <= '0;
        end else if (load_c) begin
            count_q <= word_count;
            waddr_q <= '0;
            idx_q   <= '0;
            part_q  <= '0;
        end else if (abort_c) begin
            idx_q  <= '0;
            part_q <= '0;
        end else if (write_c) begin
            waddr_q <= waddr_q + (AW+1)'(1);
            idx_q   <= '0;
            part_q  <= '0;
        end else if (accept_c) begin
            idx_q  <= idx_q + 2'd1;
            part_q <= {part_q[PART_W-BYTE_W-1:0], byte_data};
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (write_c),
        .waddr (waddr_q[AW-1:0]),
        .wdata ({part_q, byte_data}),
        .raddr (addr),
        .rdata (data)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader with a write scoreboard and a memory model.
module tb_imem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   word_count;
    logic          abort;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] addr;
    logic [31:0]   data;

    typedef struct {
        int unsigned a;
        logic [31:0] w;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem  [DEPTH];
    logic [31:0] stim_words [DEPTH];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int err_cnt   = 0;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .addr       (addr),
        .data       (data)
    );

    always #5 clk = ~clk;

    // Pulse/level counters sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        word_count = 6'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feeds bytes of stim_words MSB first; pushes each completed word to the scoreboard.
    task automatic drive_bytes(input int nbytes, input int gap, input int base_addr);
        logic [31:0] w;
        for (int i = 0; i < nbytes; i++) begin
            if (i > 0) begin
                byte_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
            w          = stim_words[i / 4];
            byte_valid = 1'b1;
            byte_data  = w[8 * (3 - (i % 4)) +: 8];
            @(posedge clk);
            #1;
            if ((i % 4) == 3) sb.push_back('{a: base_addr + i / 4, w: w});
        end
        byte_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            model_mem[e.a] = e.w;
            addr = 5'(e.a);
            #1;
            total_cnt++;
            if (data !== e.w) $display("FAIL %s_word@%0d: got %h want %h", tag, e.a, data, e.w);
            else pass_cnt++;
        end
    endtask

    task automatic check_mem_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            addr = 5'(a);
            #1;
            total_cnt++;
            if (data !== model_mem[a]) $display("FAIL %s_mem@%0d: got %h want %h", tag, a, data, model_mem[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);        else pass_cnt++;
        total_cnt++; if (byte_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", byte_ready); else pass_cnt++;
        total_cnt++; if (done !== 1'b0)       $display("FAIL reset_done: got %b want 0", done);        else pass_cnt++;
        total_cnt++; if (err !== 1'b0)        $display("FAIL reset_err: got %b want 0", err);          else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(2);
        total_cnt++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_full_load();
        int base = done_cnt;
        for (int i = 0; i < DEPTH; i++) stim_words[i] = $urandom();
        do_start(DEPTH);
        drive_bytes(4 * DEPTH, 0, 0);
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL full_done: got %b want 1", done); else pass_cnt++;
        wait_cycles(3);
        total_cnt++;
        if (done_cnt - base != 1) $display("FAIL full_done_count: got %0d want 1", done_cnt - base);
        else pass_cnt++;
        drain("full");
    endtask

    task automatic test_back_to_back();
        int dbase = done_cnt;
        int bbase = busy_cnt;
        stim_words[0] = 32'h0000_2800;
        stim_words[1] = 32'h0000_0800;
        do_start(2);
        // A start during LOAD and DONE must be ignored.
        start      = 1'b1;
        word_count = 6'd1;
        drive_bytes(8, 0, 0);
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done: got %b want 1", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_busy_in_done: got %b want 0", busy); else pass_cnt++;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done: got %b want 0", busy); else pass_cnt++;
        wait_cycles(3);
        total_cnt++;
        if (busy_cnt - bbase != 8) $display("FAIL b2b_busy_cycles: got %0d want 8", busy_cnt - bbase);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt - dbase != 1) $display("FAIL b2b_done_count: got %0d want 1", done_cnt - dbase);
        else pass_cnt++;
        drain("b2b");
    endtask

    task automatic test_gaps();
        int base = done_cnt;
        stim_words[0] = 32'h8C23_0000;
        do_start(1);
        drive_bytes(4, 2, 0);
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL gap_done: got %b want 1", done); else pass_cnt++;
        wait_cycles(3);
        total_cnt++;
        if (done_cnt - base != 1) $display("FAIL gap_done_count: got %0d want 1", done_cnt - base);
        else pass_cnt++;
        drain("gap");
        check_mem_all("gap");
    endtask

    task automatic bad_start(input int n, input string tag);
        @(posedge clk);
        #1;
        start      = 1'b1;
        word_count = 6'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        total_cnt++; if (err !== 1'b1)  $display("FAIL %s_err: got %b want 1", tag, err);   else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL %s_busy: got %b want 0", tag, busy); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (err !== 1'b0)  $display("FAIL %s_err_width: got %b want 0", tag, err); else pass_cnt++;
    endtask

    task automatic test_err();
        int ebase = err_cnt;
        int bbase = busy_cnt;
        bad_start(0, "cnt0");
        bad_start(DEPTH + 1, "cnt33");
        wait_cycles(2);
        total_cnt++;
        if (err_cnt - ebase != 2) $display("FAIL err_count: got %0d want 2", err_cnt - ebase);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt != bbase) $display("FAIL err_busy_cycles: got %0d want 0", busy_cnt - bbase);
        else pass_cnt++;
        check_mem_all("err");
    endtask

    task automatic test_abort(input int nbytes, input logic with_byte, input string tag);
        int base = done_cnt;
        for (int i = 0; i < 3; i++) stim_words[i] = $urandom();
        do_start(3);
        drive_bytes(nbytes, 0, 0);
        abort      = 1'b1;
        byte_valid = with_byte;
        byte_data  = 8'hA5;
        @(posedge clk);
        #1;
        abort      = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0)       $display("FAIL %s_busy: got %b want 0", tag, busy);        else pass_cnt++;
        total_cnt++; if (byte_ready !== 1'b0) $display("FAIL %s_ready: got %b want 0", tag, byte_ready); else pass_cnt++;
        wait_cycles(3);
        total_cnt++;
        if (done_cnt != base) $display("FAIL %s_done_count: got %0d want 0", tag, done_cnt - base);
        else pass_cnt++;
        drain(tag);
        check_mem_all(tag);
    endtask

    task automatic test_reset_midload();
        stim_words[0] = $urandom();
        stim_words[1] = $urandom();
        do_start(2);
        drive_bytes(5, 0, 0);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0)       $display("FAIL rst_mid_busy: got %b want 0", busy);        else pass_cnt++;
        total_cnt++; if (byte_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", byte_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        drain("rst_mid");
        check_mem_all("rst_mid");
        stim_words[0] = $urandom();
        do_start(1);
        drive_bytes(4, 0, 0);
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL rst_reload_done: got %b want 1", done); else pass_cnt++;
        drain("rst_reload");
        check_mem_all("rst_reload");
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        word_count = '0;
        abort      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        addr       = '0;
        test_reset();
        test_full_load();
        test_back_to_back();
        test_gaps();
        test_err();
        test_abort(6, 1'b0, "abort6");
        test_abort(7, 1'b1, "abort7_prio");
        test_reset_midload();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
